// File: rtl/keycode_conditioner.sv
// Frame-rate keyboard conditioner: debounces direction keys, enforces a minimum hold,
// and turns space presses into rate-limited single-frame flap pulses. All outputs registered.
module keycode_conditioner #(
    parameter int STABLE_FRAMES = 2,
    parameter int MIN_HOLD      = 4,
    parameter int COOLDOWN      = 8,
    parameter int CNT_W         = 4
) (
    input  logic             Reset,
    input  logic             frame_clk,
    input  logic [7:0]       keycode_in,
    output logic [7:0]       keycode_out,
    output logic             key_valid,
    output logic             key_changed,
    output logic             flap_pulse,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        QUALIFY = 2'd1,
        ACTIVE  = 2'd2,
        HOLD    = 2'd3
    } state_t;

    localparam logic [7:0]       KEY_A      = 8'h04;
    localparam logic [7:0]       KEY_D      = 8'h07;
    localparam logic [7:0]       KEY_S      = 8'h16;
    localparam logic [7:0]       KEY_W      = 8'h1A;
    localparam logic [7:0]       KEY_SPACE  = 8'h2C;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] STABLE_END = CNT_W'(STABLE_FRAMES - 1);
    localparam logic [CNT_W-1:0] HOLD_MAX   = CNT_W'(MIN_HOLD);
    localparam logic [CNT_W-1:0] COOL_INIT  = CNT_W'(COOLDOWN);

    state_t           state_q, state_d;
    logic [7:0]       cand_q, cand_d;
    logic [CNT_W-1:0] stab_cnt_q, stab_cnt_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0] cool_cnt_q, cool_cnt_d;
    logic             prev_space_q, prev_space_d;
    logic [7:0]       keycode_out_q, keycode_out_d;
    logic             key_valid_q, key_valid_d;
    logic             key_changed_q, key_changed_d;
    logic             flap_pulse_q, flap_pulse_d;

    logic             in_dir;
    logic             in_match_out;
    logic             space_now;
    logic             release_key;
    logic [CNT_W-1:0] hold_inc;
    logic [CNT_W-1:0] stab_inc;

    assign in_dir       = (keycode_in == KEY_A) || (keycode_in == KEY_D) ||
                          (keycode_in == KEY_S) || (keycode_in == KEY_W);
    assign in_match_out = (keycode_in == keycode_out_q);
    assign space_now    = (keycode_in == KEY_SPACE);
    assign hold_inc     = (hold_cnt_q >= HOLD_MAX) ? HOLD_MAX : hold_cnt_q + CNT_ONE;
    assign stab_inc     = (stab_cnt_q == CNT_MAX) ? CNT_MAX : stab_cnt_q + CNT_ONE;

    // Direction path
    always_comb begin
        state_d       = state_q;
        cand_d        = cand_q;
        stab_cnt_d    = stab_cnt_q;
        hold_cnt_d    = hold_cnt_q;
        keycode_out_d = keycode_out_q;
        key_valid_d   = key_valid_q;
        key_changed_d = 1'b0;
        release_key   = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_dir) begin
                    cand_d     = keycode_in;
                    stab_cnt_d = CNT_ONE;
                    state_d    = QUALIFY;
                end
            end
            QUALIFY: begin
                if (keycode_in == cand_q) begin
                    if (stab_cnt_q == STABLE_END) begin
                        state_d       = ACTIVE;
                        keycode_out_d = cand_q;
                        key_valid_d   = 1'b1;
                        key_changed_d = 1'b1;
                        hold_cnt_d    = CNT_ONE;
                        stab_cnt_d    = '0;
                    end else begin
                        stab_cnt_d = stab_inc;
                    end
                end else if (in_dir) begin
                    cand_d     = keycode_in;
                    stab_cnt_d = CNT_ONE;
                end else begin
                    state_d    = IDLE;
                    stab_cnt_d = '0;
                end
            end
            ACTIVE: begin
                if (in_match_out) begin
                    hold_cnt_d = hold_inc;
                end else if (hold_cnt_q >= HOLD_MAX) begin
                    release_key = 1'b1;
                end else begin
                    state_d    = HOLD;
                    hold_cnt_d = hold_inc;
                end
            end
            HOLD: begin
                if (in_match_out) begin
                    state_d    = ACTIVE;
                    hold_cnt_d = hold_inc;
                end else if (hold_cnt_q >= HOLD_MAX) begin
                    release_key = 1'b1;
                end else begin
                    hold_cnt_d = hold_inc;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A release always drops to zero first; a new key must re-qualify.
        if (release_key) begin
            keycode_out_d = 8'h00;
            key_valid_d   = 1'b0;
            key_changed_d = 1'b1;
            hold_cnt_d    = '0;
            if (in_dir) begin
                state_d    = QUALIFY;
                cand_d     = keycode_in;
                stab_cnt_d = CNT_ONE;
            end else begin
                state_d    = IDLE;
                stab_cnt_d = '0;
            end
        end
    end

    // Flap path
    always_comb begin
        prev_space_d = space_now;
        flap_pulse_d = 1'b0;
        cool_cnt_d   = (cool_cnt_q == '0) ? '0 : cool_cnt_q - CNT_ONE;
        if (space_now && !prev_space_q && (cool_cnt_q == '0)) begin
            flap_pulse_d = 1'b1;
            cool_cnt_d   = COOL_INIT;
        end
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q       <= IDLE;
            cand_q        <= 8'h00;
            stab_cnt_q    <= '0;
            hold_cnt_q    <= '0;
            cool_cnt_q    <= '0;
            prev_space_q  <= 1'b0;
            keycode_out_q <= 8'h00;
            key_valid_q   <= 1'b0;
            key_changed_q <= 1'b0;
            flap_pulse_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cand_q        <= cand_d;
            stab_cnt_q    <= stab_cnt_d;
            hold_cnt_q    <= hold_cnt_d;
            cool_cnt_q    <= cool_cnt_d;
            prev_space_q  <= prev_space_d;
            keycode_out_q <= keycode_out_d;
            key_valid_q   <= key_valid_d;
            key_changed_q <= key_changed_d;
            flap_pulse_q  <= flap_pulse_d;
        end
    end

    assign keycode_out = keycode_out_q;
    assign key_valid   = key_valid_q;
    assign key_changed = key_changed_q;
    assign flap_pulse  = flap_pulse_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_keycode_conditioner.sv
// Scoreboard bench for keycode_conditioner: a history-based reference model predicts each
// frame's outputs into a queue; a monitor pops and compares one entry per frame edge.
module tb_keycode_conditioner;

    localparam int STABLE_FRAMES = 2;
    localparam int MIN_HOLD      = 4;
    localparam int COOLDOWN      = 8;
    localparam int CNT_W         = 4;

    logic       Reset;
    logic       frame_clk;
    logic [7:0] keycode_in;
    logic [7:0] keycode_out;
    logic       key_valid;
    logic       key_changed;
    logic       flap_pulse;
    logic [1:0] state_dbg;

    keycode_conditioner #(
        .STABLE_FRAMES(STABLE_FRAMES),
        .MIN_HOLD     (MIN_HOLD),
        .COOLDOWN     (COOLDOWN),
        .CNT_W        (CNT_W)
    ) dut (
        .Reset      (Reset),
        .frame_clk  (frame_clk),
        .keycode_in (keycode_in),
        .keycode_out(keycode_out),
        .key_valid  (key_valid),
        .key_changed(key_changed),
        .flap_pulse (flap_pulse),
        .state_dbg  (state_dbg)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    typedef struct {
        logic [7:0] ko;
        logic       kv;
        logic       kc;
        logic       fp;
        logic [1:0] st;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: described by run lengths and frame ages, not by FSM registers.
    logic [7:0] m_out;
    int         m_age;
    logic [7:0] m_run_key;
    int         m_run;
    bit         m_in_hold;
    bit         m_prev_space;
    int         frame_no;
    int         m_last_pulse;

    function automatic bit is_dir(input logic [7:0] k);
        return (k == 8'h04) || (k == 8'h07) || (k == 8'h16) || (k == 8'h1A);
    endfunction

    task automatic model_reset();
        m_out        = 8'h00;
        m_age        = 0;
        m_run_key    = 8'h00;
        m_run        = 0;
        m_in_hold    = 1'b0;
        m_prev_space = 1'b0;
        m_last_pulse = frame_no - COOLDOWN - 1;
    endtask

    task automatic model_step(input logic [7:0] k, output exp_t e);
        bit kc;
        bit fp;
        kc = 1'b0;
        fp = 1'b0;
        frame_no++;
        if (m_out != 8'h00) begin
            if (k != m_out && m_age >= MIN_HOLD) begin
                m_out = 8'h00;
                m_age = 0;
                kc    = 1'b1;
                if (is_dir(k)) begin
                    m_run_key = k;
                    m_run     = 1;
                end else begin
                    m_run = 0;
                end
            end else begin
                m_age++;
                m_in_hold = (k != m_out);
            end
        end else if (is_dir(k)) begin
            if (m_run > 0 && k == m_run_key) m_run++;
            else begin
                m_run_key = k;
                m_run     = 1;
            end
            if (m_run >= STABLE_FRAMES) begin
                m_out     = k;
                m_age     = 1;
                kc        = 1'b1;
                m_run     = 0;
                m_in_hold = 1'b0;
            end
        end else begin
            m_run = 0;
        end
        // A space press is honoured if it is a fresh press and more than COOLDOWN frames passed.
        if (k == 8'h2C && !m_prev_space && (frame_no - m_last_pulse) > COOLDOWN) begin
            fp           = 1'b1;
            m_last_pulse = frame_no;
        end
        m_prev_space = (k == 8'h2C);
        e.ko = m_out;
        e.kv = (m_out != 8'h00);
        e.kc = kc;
        e.fp = fp;
        if (m_out != 8'h00) e.st = m_in_hold ? 2'd3 : 2'd2;
        else                e.st = (m_run > 0) ? 2'd1 : 2'd0;
    endtask

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act == expv) n_pass++;
        else $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, expv);
    endtask

    task automatic step(input logic [7:0] k);
        exp_t e;
        @(negedge frame_clk);
        keycode_in = k;
        model_step(k, e);
        exp_q.push_back(e);
    endtask

    task automatic step_n(input logic [7:0] k, input int n);
        for (int i = 0; i < n; i++) step(k);
    endtask

    // Assert reset asynchronously between edges and check outputs clear at once.
    task automatic async_reset();
        @(posedge frame_clk);
        #3;
        Reset = 1'b1;
        #1;
        chk("rst_keycode_out", keycode_out, 0);
        chk("rst_key_valid", key_valid, 0);
        chk("rst_key_changed", key_changed, 0);
        chk("rst_flap_pulse", flap_pulse, 0);
        chk("rst_state", state_dbg, 0);
        chk("rst_queue_empty", exp_q.size(), 0);
        model_reset();
    endtask

    task automatic release_reset_step(input logic [7:0] k);
        exp_t e;
        @(negedge frame_clk);
        Reset      = 1'b0;
        keycode_in = k;
        model_step(k, e);
        exp_q.push_back(e);
    endtask

    // Monitor: one expected entry per edge, compared just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge frame_clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("keycode_out", keycode_out, e.ko);
                chk("key_valid", key_valid, e.kv);
                chk("key_changed", key_changed, e.kc);
                chk("flap_pulse", flap_pulse, e.fp);
                chk("state_dbg", state_dbg, e.st);
            end
        end
    end

    initial begin
        logic [7:0] keys [8];
        logic [7:0] k;
        int         len;
        keys = '{8'h00, 8'h04, 8'h07, 8'h16, 8'h1A, 8'h2C, 8'h2C, 8'h55};
        frame_no   = 0;
        Reset      = 1'b1;
        keycode_in = 8'h00;
        model_reset();
        #1;
        chk("init_keycode_out", keycode_out, 0);
        chk("init_state", state_dbg, 0);
        repeat (2) @(posedge frame_clk);

        // Steady D accepted on the second edge; then W held and dropped.
        release_reset_step(8'h07);
        step_n(8'h07, 5);
        step_n(8'h00, 6);
        step_n(8'h1A, 2);
        step_n(8'h00, 6);
        // Glitch resets the candidate.
        step(8'h04); step(8'h16); step(8'h04); step(8'h04);
        // Held A then D: release first, re-qualify D.
        step_n(8'h04, 4);
        step_n(8'h07, 5);
        step_n(8'h00, 6);
        // Space held, then tapped every 3 frames.
        step_n(8'h2C, 20);
        step_n(8'h00, 10);
        for (int i = 0; i < 8; i++) begin
            step(8'h2C);
            step_n(8'h00, 2);
        end
        // Reset during HOLD and cooldown, then space must pulse at once.
        step(8'h2C);
        step_n(8'h1A, 2);
        step(8'h00);
        async_reset();
        release_reset_step(8'h2C);
        step_n(8'h00, 3);

        // Randomized runs, with occasional async resets.
        for (int r = 0; r < 120; r++) begin
            k   = keys[$urandom_range(0, 7)];
            len = $urandom_range(1, 6);
            step_n(k, len);
            if ($urandom_range(0, 39) == 0) begin
                async_reset();
                release_reset_step(8'h00);
            end
        end

        repeat (3) @(posedge frame_clk);
        #2;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
